// File: rtl/counterdown16_4ch_ctrl.sv
// Four programmable 16-bit down counters with start/stop/auto-reload and a
// round-robin merged expiry event stream (valid/ready) with sticky overflow flags.
module counterdown16_4ch_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_ch,
    input  logic [WIDTH-1:0] cfg_load,
    input  logic             cfg_auto,
    input  logic [3:0]       start,
    input  logic [3:0]       stop,
    output logic [WIDTH-1:0] cnt0_16,
    output logic [WIDTH-1:0] cnt1_16,
    output logic [WIDTH-1:0] cnt2_16,
    output logic [WIDTH-1:0] cnt3_16,
    output logic [3:0]       busy,
    output logic             evt_valid,
    output logic [1:0]       evt_ch,
    input  logic             evt_ready,
    output logic [3:0]       overflow
);

    logic [3:0][WIDTH-1:0] cnt_vec;
    logic [3:0]            busy_vec;
    logic [3:0]            pending_vec;
    logic [3:0]            ovf_vec;
    logic [3:0]            grant;

    logic       evt_valid_q, evt_valid_d;
    logic [1:0] evt_ch_q, evt_ch_d;
    logic [1:0] rr_q, rr_d;
    logic       found;
    logic [1:0] idx;

    // Arbiter: a new grant is only taken when the output register is free.
    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_ch_d    = evt_ch_q;
        rr_d        = rr_q;
        grant       = '0;
        found       = 1'b0;
        idx         = '0;
        if (!evt_valid_q || evt_ready) begin
            evt_valid_d = 1'b0;
            for (int k = 0; k < 4; k++) begin
                idx = rr_q + 2'(k);
                if (!found && pending_vec[idx]) begin
                    found       = 1'b1;
                    grant[idx]  = 1'b1;
                    evt_ch_d    = idx;
                    rr_d        = idx + 2'd1;
                    evt_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_valid_q <= 1'b0;
            evt_ch_q    <= '0;
            rr_q        <= '0;
        end else begin
            evt_valid_q <= evt_valid_d;
            evt_ch_q    <= evt_ch_d;
            rr_q        <= rr_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [WIDTH-1:0] load_q, load_d;
        logic [WIDTH-1:0] cnt_q, cnt_d;
        logic             auto_q, auto_d;
        logic             busy_q, busy_d;
        logic             pend_q, pend_d;
        logic             ovf_q, ovf_d;
        logic             expire;
        logic             still_pend;

        always_comb begin
            load_d     = load_q;
            auto_d     = auto_q;
            cnt_d      = cnt_q;
            busy_d     = busy_q;
            ovf_d      = ovf_q;
            expire     = 1'b0;
            still_pend = pend_q && !grant[gi];
            if (cfg_we && (cfg_ch == 2'(gi))) begin
                load_d = cfg_load;
                auto_d = cfg_auto;
            end
            if (stop[gi]) begin
                busy_d = 1'b0;
            end else if (start[gi]) begin
                cnt_d  = load_q;
                busy_d = 1'b1;
                ovf_d  = 1'b0;
            end else if (busy_q) begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    expire = 1'b1;
                    if (auto_q) cnt_d = load_q;
                    else        busy_d = 1'b0;
                end
            end
            // An expiry landing on an unserved pending bit is merged and flagged.
            pend_d = still_pend || expire;
            if (expire && still_pend) ovf_d = 1'b1;
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                load_q <= '0;
                auto_q <= 1'b0;
                cnt_q  <= '0;
                busy_q <= 1'b0;
                pend_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                load_q <= load_d;
                auto_q <= auto_d;
                cnt_q  <= cnt_d;
                busy_q <= busy_d;
                pend_q <= pend_d;
                ovf_q  <= ovf_d;
            end
        end

        assign cnt_vec[gi]     = cnt_q;
        assign busy_vec[gi]    = busy_q;
        assign pending_vec[gi] = pend_q;
        assign ovf_vec[gi]     = ovf_q;
    end

    assign cnt0_16   = cnt_vec[0];
    assign cnt1_16   = cnt_vec[1];
    assign cnt2_16   = cnt_vec[2];
    assign cnt3_16   = cnt_vec[3];
    assign busy      = busy_vec;
    assign overflow  = ovf_vec;
    assign evt_valid = evt_valid_q;
    assign evt_ch    = evt_ch_q;

endmodule
